// File: rtl/ife_pkg.sv
// Shared constants and types for the IFE block builder.
package ife_pkg;

  // RISC-V "addi x0, x0, 0" used to pad unused block slots.
  localparam logic [31:0] IFE_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BB_IDLE,
    BB_FILL,
    BB_EMIT
  } bb_state_t;

endpackage

// File: rtl/ife_idle_timer.sv
// Idle-cycle counter: counts enabled cycles, clears on demand, flags the last idle cycle.
// Cycles == 0 disables expiry entirely.
module ife_idle_timer #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over count; the counter never needs to pass Cycles-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (Cycles != 0) && enable_i && (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/ife_block_builder.sv
// Packs a serial instruction stream into fixed-size, ID-tagged, NOP-padded blocks.
// Optional statistics counters are enabled by defining IFE_BLOCK_STATS_EN.
module ife_block_builder
  import ife_pkg::*;
#(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INSTR_WIDTH-1:0]            instr_in,
  input  logic                              instr_valid,
  input  logic                              instr_last,
  output logic                              instr_ready,
  output logic [BLOCK_ID_WIDTH-1:0]         block_id_out,
  output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_data_out,
  output logic [$clog2(BLOCK_SIZE+1)-1:0]   block_len_out,
  output logic                              block_valid_out,
  input  logic                              block_ready_in
`ifdef IFE_BLOCK_STATS_EN
  ,
  output logic [31:0]                       stat_blocks_out,
  output logic [31:0]                       stat_padded_out
`endif
);

  localparam int unsigned PtrW = $clog2(BLOCK_SIZE + 1);

  bb_state_t                 state_q, state_d;
  logic [PtrW-1:0]           ptr_q, ptr_d;
  logic [INSTR_WIDTH-1:0]    slot_q [BLOCK_SIZE];
  logic [INSTR_WIDTH-1:0]    slot_d [BLOCK_SIZE];
  logic [BLOCK_ID_WIDTH-1:0] id_q, id_d;

  logic            accept, handshake, close, expire;
  logic [PtrW-1:0] len_next;

  assign accept    = instr_valid && instr_ready;
  assign handshake = block_valid_out && block_ready_in;
  assign len_next  = accept ? ptr_q + 1'b1 : ptr_q;

  ife_idle_timer #(
    .Cycles (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (accept || (state_q != BB_FILL)),
    .enable_i ((state_q == BB_FILL) && !accept),
    .expire_o (expire)
  );

  // Close condition: block full, explicit last, or idle timeout.
  always_comb begin
    close = 1'b0;
    unique case (state_q)
      BB_IDLE: close = accept && instr_last;
      BB_FILL: close = (accept && ((len_next == PtrW'(BLOCK_SIZE)) || instr_last)) || expire;
      default: close = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BB_IDLE: if (accept) state_d = close ? BB_EMIT : BB_FILL;
      BB_FILL: if (close) state_d = BB_EMIT;
      BB_EMIT: if (handshake) state_d = BB_IDLE;
      default: state_d = BB_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    instr_ready     = (state_q != BB_EMIT);
    block_valid_out = (state_q == BB_EMIT);
  end

  // Slot, pointer and ID next-state: write on accept, pad on close, clear on emit.
  always_comb begin
    ptr_d  = ptr_q;
    slot_d = slot_q;
    id_d   = id_q;
    if (handshake) begin
      ptr_d = '0;
      id_d  = id_q + 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) slot_d[i] = '0;
    end else begin
      if (accept) begin
        ptr_d = len_next;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          if (PtrW'(i) == ptr_q) slot_d[i] = instr_in;
        end
      end
      if (close) begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          if (PtrW'(i) >= len_next) slot_d[i] = INSTR_WIDTH'(IFE_NOP);
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      id_q  <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) slot_q[i] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      id_q   <= id_d;
      slot_q <= slot_d;
    end
  end

  // Flatten slots onto the block bus, slot 0 in the low bits.
  always_comb begin
    block_data_out = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      block_data_out[i*INSTR_WIDTH +: INSTR_WIDTH] = slot_q[i];
    end
  end

  assign block_id_out  = id_q;
  assign block_len_out = ptr_q;

`ifdef IFE_BLOCK_STATS_EN
  logic [31:0] stat_blocks_q, stat_padded_q;

  // Saturating emit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_blocks_q <= '0;
      stat_padded_q <= '0;
    end else if (handshake) begin
      if (stat_blocks_q != 32'hFFFF_FFFF) stat_blocks_q <= stat_blocks_q + 32'd1;
      if ((ptr_q < PtrW'(BLOCK_SIZE)) && (stat_padded_q != 32'hFFFF_FFFF)) begin
        stat_padded_q <= stat_padded_q + 32'd1;
      end
    end
  end

  assign stat_blocks_out = stat_blocks_q;
  assign stat_padded_out = stat_padded_q;
`endif

endmodule

// File: tb/tb_ife_block_builder.sv
// Scoreboard bench for ife_block_builder (BLOCK_SIZE=4, INSTR_WIDTH=32, TIMEOUT=16).
module tb_ife_block_builder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [7:0]   id;
    logic [127:0] data;
    logic [2:0]   len;
  } blk_t;

  logic         clk;
  logic         rst;
  logic [31:0]  instr_in;
  logic         instr_valid;
  logic         instr_last;
  logic         instr_ready;
  logic [7:0]   block_id_out;
  logic [127:0] block_data_out;
  logic [2:0]   block_len_out;
  logic         block_valid_out;
  logic         block_ready_in;
`ifdef IFE_BLOCK_STATS_EN
  logic [31:0]  stat_blocks_out;
  logic [31:0]  stat_padded_out;
`endif

  ife_block_builder #(
    .BLOCK_ID_WIDTH (8),
    .INSTR_WIDTH    (32),
    .BLOCK_SIZE     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (instr_in),
    .instr_valid     (instr_valid),
    .instr_last      (instr_last),
    .instr_ready     (instr_ready),
    .block_id_out    (block_id_out),
    .block_data_out  (block_data_out),
    .block_len_out   (block_len_out),
    .block_valid_out (block_valid_out),
    .block_ready_in  (block_ready_in)
`ifdef IFE_BLOCK_STATS_EN
    ,
    .stat_blocks_out (stat_blocks_out),
    .stat_padded_out (stat_padded_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  blk_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_id = 8'd0;
  int          n_blocks = 0;
  int          n_pad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] s0, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push_blk(input logic [127:0] data, input logic [2:0] len);
    blk_t b;
    b.id   = exp_id;
    b.data = data;
    b.len  = len;
    sb.push_back(b);
    exp_id = exp_id + 8'd1;
    n_blocks++;
    if (len < 3'd4) n_pad++;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [31:0] d, input logic last);
    int budget;
    instr_in    = d;
    instr_last  = last;
    instr_valid = 1'b1;
    budget      = 0;
    while (!instr_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!instr_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: instr_ready stuck at %0b, required 1", instr_ready);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    instr_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d blocks still expected, required 0", sb.size());
    end
  endtask

  // Monitor: compare each block at its handshake against the scoreboard head.
  always begin
    blk_t e;
    @(negedge clk);
    #2;
    if (rst && block_valid_out && block_ready_in) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_block: id %h len %0d, required none", block_id_out,
                 block_len_out);
      end else begin
        e = sb.pop_front();
        chk("blk_id", 128'(block_id_out), 128'(e.id));
        chk("blk_data", block_data_out, e.data);
        chk("blk_len", 128'(block_len_out), 128'(e.len));
      end
    end
  end

  initial begin
    logic [127:0] hold_data;
    logic [7:0]   hold_id;

    rst            = 1'b0;
    instr_in       = '0;
    instr_valid    = 1'b0;
    instr_last     = 1'b0;
    block_ready_in = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_valid", 128'(block_valid_out), 128'd0);
    chk("rst_id", 128'(block_id_out), 128'd0);
    chk("rst_data", block_data_out, 128'd0);
    chk("rst_len", 128'(block_len_out), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(instr_ready), 128'd1);

    // 1: full block, back to back; one-cycle bubble.
    push_blk(mk(32'h11, 32'h12, 32'h13, 32'h14), 3'd4);
    send(32'h11, 1'b0);
    send(32'h12, 1'b0);
    send(32'h13, 1'b0);
    send(32'h14, 1'b0);
    chk("t1_valid_latency", 128'(block_valid_out), 128'd1);
    chk("t1_ready_low", 128'(instr_ready), 128'd0);
    @(negedge clk);
    chk("t1_ready_back", 128'(instr_ready), 128'd1);
    chk("t1_valid_drop", 128'(block_valid_out), 128'd0);

    // 2: instr_last closes a partial block.
    push_blk(mk(32'h21, 32'h22, NOP, NOP), 3'd2);
    send(32'h21, 1'b0);
    send(32'h22, 1'b1);
    idle(2);

    // 3a: timeout closes at idle cycle 16.
    push_blk(mk(32'h31, NOP, NOP, NOP), 3'd1);
    send(32'h31, 1'b0);
    idle(15);
    chk("t3_no_early_close", 128'(block_valid_out), 128'd0);
    idle(1);
    chk("t3_timeout_close", 128'(block_valid_out), 128'd1);
    idle(2);

    // 3b: accept at idle cycle 15 restarts the counter.
    push_blk(mk(32'h41, 32'h42, 32'h43, NOP), 3'd3);
    send(32'h41, 1'b0);
    idle(14);
    send(32'h42, 1'b0);
    idle(10);
    chk("t3b_restart", 128'(block_valid_out), 128'd0);
    send(32'h43, 1'b1);
    idle(2);

    // 3c: accept in the expiry cycle wins over the timeout.
    push_blk(mk(32'h51, 32'h52, 32'h53, 32'h54), 3'd4);
    send(32'h51, 1'b0);
    idle(15);
    send(32'h52, 1'b0);
    chk("t3c_accept_wins", 128'(block_valid_out), 128'd0);
    send(32'h53, 1'b0);
    send(32'h54, 1'b0);
    idle(2);

    // 4: back-pressure in EMIT holds everything; held instr is taken after release.
    block_ready_in = 1'b0;
    hold_id        = exp_id;
    hold_data      = mk(32'h61, 32'h62, 32'h63, 32'h64);
    push_blk(hold_data, 3'd4);
    send(32'h61, 1'b0);
    send(32'h62, 1'b0);
    send(32'h63, 1'b0);
    send(32'h64, 1'b0);
    instr_in    = 32'h71;
    instr_last  = 1'b1;
    instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", 128'(block_valid_out), 128'd1);
      chk("t4_hold_ready", 128'(instr_ready), 128'd0);
      chk("t4_hold_data", block_data_out, hold_data);
      chk("t4_hold_id", 128'(block_id_out), 128'(hold_id));
      @(negedge clk);
    end
    block_ready_in = 1'b1;
    push_blk(mk(32'h71, NOP, NOP, NOP), 3'd1);
    send(32'h71, 1'b1);
    idle(2);

    // instr_last on the filling accept gives one block only.
    push_blk(mk(32'h81, 32'h82, 32'h83, 32'h84), 3'd4);
    send(32'h81, 1'b0);
    send(32'h82, 1'b0);
    send(32'h83, 1'b0);
    send(32'h84, 1'b1);
    idle(2);
    chk("t_last_full_single", 128'(block_valid_out), 128'd0);

    // 5: 257 full blocks, ID wraps.
    for (int b = 0; b < 257; b++) begin
      logic [31:0] base;
      base = 32'h1000 + 32'(b * 4);
      push_blk(mk(base, base + 1, base + 2, base + 3), 3'd4);
      for (int s = 0; s < 4; s++) send(base + 32'(s), 1'b0);
    end
    drain();
`ifdef IFE_BLOCK_STATS_EN
    chk("stat_blocks", 128'(stat_blocks_out), 128'(n_blocks));
    chk("stat_padded", 128'(stat_padded_out), 128'(n_pad));
`endif

    // 6: reset mid-fill discards the partial block and restarts IDs.
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(block_valid_out), 128'd0);
    chk("t6_rst_len", 128'(block_len_out), 128'd0);
    chk("t6_rst_id", 128'(block_id_out), 128'd0);
    @(negedge clk);
    rst    = 1'b1;
    exp_id = 8'd0;
    @(negedge clk);
    push_blk(mk(32'hB1, 32'hB2, 32'hB3, 32'hB4), 3'd4);
    send(32'hB1, 1'b0);
    send(32'hB2, 1'b0);
    send(32'hB3, 1'b0);
    send(32'hB4, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
